fe_stub_concentrator: RTL and testbench

Collects the three per-bunch-crossing hit channels produced by one front-end chip model and serializes them into a single tagged stub stream with valid/ready flow control. It sits directly downstream of the FE chip: each bunch crossing it captures up to three 13-bit stubs, tags each with BX number, FE id and slot index, and buffers them in a FIFO for the next stage (layer/sector aggregation). Losses are counted, never silent.

---
 rtl/tt_stub_pkg.sv | 33 +++
 rtl/stub_fifo.sv | 59 +++++
 rtl/fe_stub_concentrator.sv | 124 ++++++++++++
 tb/tb_fe_stub_concentrator.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tt_stub_pkg.sv
// Shared stub definitions for the front-end concentrator and the downstream
// layer/sector aggregator.
//   STUB_W/BEND_W/HIT_W : raw hit word {stub, bend}
//   FE_W/SLOT_W         : FE chip index and slot (1..3) tag widths
//   tagged_stub_t       : full output word for the default 8-bit BX tag
package tt_stub_pkg;
  localparam int STUB_W   = 8;
  localparam int BEND_W   = 5;
  localparam int HIT_W    = 13;
  localparam int FE_W     = 4;
  localparam int SLOT_W   = 2;
  localparam int BX_W_DEF = 8;

  // Everything in an output word below the BX tag.
  typedef struct packed {
    logic [FE_W-1:0]   fe;
    logic [SLOT_W-1:0] slot;
    logic [STUB_W-1:0] stub;
    logic [BEND_W-1:0] bend;
  } stub_body_t;

  localparam int BODY_W = $bits(stub_body_t);

  // Output word layout when BX_W = BX_W_DEF.
  typedef struct packed {
    logic [BX_W_DEF-1:0] bx;
    stub_body_t          body;
  } tagged_stub_t;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction
endpackage

// File: rtl/stub_fifo.sv
// Synchronous FIFO with show-ahead read.
//   wr_en/wr_data : push (ignored while full, even if a pop happens that cycle)
//   rd_en/rd_data : pop (ignored while empty); rd_data shows the head word,
//                   or the last popped word while empty (0 after reset)
//   full/empty/level : occupancy from the previous edge
module stub_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      lvl_q;
  logic [WIDTH-1:0] last_q;
  logic             do_wr, do_rd;

  assign full    = (lvl_q == FULL_LVL);
  assign empty   = (lvl_q == '0);
  assign level   = lvl_q;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? last_q : mem[rp_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) begin
        rp_q   <= rp_q + 1'b1;
        last_q <= mem[rp_q];
      end
      case ({do_wr, do_rd})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end
endmodule

// File: rtl/fe_stub_concentrator.sv
// Front-end stub concentrator: latches the three hit channels on each BX
// strobe into a staging bank, drains valid slots (1, 2, 3 order) one per cycle
// into an output FIFO tagged {bx, fe_id, slot, stub, bend}, and counts hits
// lost when a new strobe overwrites a bank that is still draining.
//   clk, rst_n           : clock, async active-low reset
//   bx_strobe            : hit channels hold this BX's final values
//   fe_id                : static FE index copied into each word
//   hitN_dv / hitN_data  : per-slot hit flag and {stub, bend}
//   out_valid/ready/data : show-ahead valid/ready stream
//   bx_cnt, drop_cnt, fifo_level : status
module fe_stub_concentrator
  import tt_stub_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BX_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bx_strobe,
  input  logic [3:0]                    fe_id,
  input  logic                          hit1_dv,
  input  logic                          hit2_dv,
  input  logic                          hit3_dv,
  input  logic [12:0]                   hit1_data,
  input  logic [12:0]                   hit2_data,
  input  logic [12:0]                   hit3_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BX_W+18:0]              out_data,
  output logic [BX_W-1:0]               bx_cnt,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int OUT_W = BX_W + BODY_W;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [2:0]              dv_q, dv_d;
  logic [2:0][HIT_W-1:0]   hit_q, hit_d;
  logic [BX_W-1:0]         bank_bx_q, bank_bx_d;
  logic [BX_W-1:0]         bx_q, bx_d;
  logic [15:0]             drop_q, drop_d;

  logic                    wr_en, full, empty;
  logic [2:0]              wr_oh;
  logic [1:0]              wr_idx;
  logic [OUT_W-1:0]        wr_data;
  stub_body_t              body;
  logic [16:0]             drop_sum;

  // Lowest-numbered valid slot wins.
  always_comb begin
    wr_oh  = 3'b000;
    wr_idx = 2'd0;
    if (dv_q[0])      begin wr_oh = 3'b001; wr_idx = 2'd0; end
    else if (dv_q[1]) begin wr_oh = 3'b010; wr_idx = 2'd1; end
    else if (dv_q[2]) begin wr_oh = 3'b100; wr_idx = 2'd2; end
  end

  // A full FIFO stalls the bank; nothing is written through on a same-cycle pop.
  assign wr_en = (state_q == DRAIN) && !full && (dv_q != 3'b000);

  always_comb begin
    body      = '0;
    body.fe   = fe_id;
    body.slot = wr_idx + 2'd1;
    body.stub = hit_q[wr_idx][HIT_W-1:BEND_W];
    body.bend = hit_q[wr_idx][BEND_W-1:0];
  end
  assign wr_data = {bank_bx_q, body};

  always_comb begin
    dv_d      = wr_en ? (dv_q & ~wr_oh) : dv_q;
    hit_d     = hit_q;
    bank_bx_d = bank_bx_q;
    bx_d      = bx_q;
    drop_sum  = {1'b0, drop_q};
    if (bx_strobe) begin
      // Slots still pending after this cycle's write are overwritten.
      drop_sum  = {1'b0, drop_q} + 17'(popcnt3(dv_d));
      dv_d      = {hit3_dv, hit2_dv, hit1_dv};
      hit_d     = {hit3_data, hit2_data, hit1_data};
      bank_bx_d = bx_q;
      bx_d      = bx_q + 1'b1;
    end
    drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    state_d = (dv_d != 3'b000) ? DRAIN : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dv_q      <= '0;
      hit_q     <= '0;
      bank_bx_q <= '0;
      bx_q      <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      dv_q      <= dv_d;
      hit_q     <= hit_d;
      bank_bx_q <= bank_bx_d;
      bx_q      <= bx_d;
      drop_q    <= drop_d;
    end
  end

  stub_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign out_valid = !empty;
  assign bx_cnt    = bx_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_fe_stub_concentrator.sv
module tb_fe_stub_concentrator;
  localparam int DEPTH = 16;
  localparam int BXW   = 8;
  localparam int OW    = BXW + 19;

  logic clk = 0, rst_n = 0, bx_strobe = 0, out_ready = 0;
  logic [3:0] fe_id = 0;
  logic hit1_dv = 0, hit2_dv = 0, hit3_dv = 0;
  logic [12:0] hit1_data = 0, hit2_data = 0, hit3_data = 0;
  logic out_valid;
  logic [OW-1:0] out_data;
  logic [BXW-1:0] bx_cnt;
  logic [15:0] drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  int tests = 0, fails = 0;

  fe_stub_concentrator #(.FIFO_DEPTH(DEPTH), .BX_W(BXW)) dut (
    .clk(clk), .rst_n(rst_n), .bx_strobe(bx_strobe), .fe_id(fe_id),
    .hit1_dv(hit1_dv), .hit2_dv(hit2_dv), .hit3_dv(hit3_dv),
    .hit1_data(hit1_data), .hit2_data(hit2_data), .hit3_data(hit3_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bx_cnt(bx_cnt), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending hits of the latest BX, words queued in the
  // FIFO, occupancy, BX and drop counts.
  logic [OW-1:0] bank[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] last_exp;
  int occ, bx_m, drop_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank.delete(); exp_q.delete();
      occ = 0; bx_m = 0; drop_m = 0; last_exp = '0;
    end else begin
      automatic int wr = 0;
      automatic int rd = (out_ready && occ > 0) ? 1 : 0;
      automatic logic [2:0] dv = {hit3_dv, hit2_dv, hit1_dv};
      automatic logic [12:0] hd [3] = '{hit1_data, hit2_data, hit3_data};
      if (bank.size() > 0 && occ < DEPTH) begin
        exp_q.push_back(bank.pop_front());
        wr = 1;
      end
      if (bx_strobe) begin
        drop_m = (drop_m + bank.size() > 65535) ? 65535 : drop_m + bank.size();
        bank.delete();
        for (int s = 0; s < 3; s++)
          if (dv[s]) bank.push_back({8'(bx_m), fe_id, 2'(s + 1), hd[s]});
        bx_m = (bx_m + 1) % (1 << BXW);
      end
      occ = occ + wr - rd;
    end
  end

  // Monitor: status every cycle, word compare on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_bx", 32'(bx_cnt), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_data", 32'(out_data), 0);
    end else begin
      chk("level", 32'(fifo_level), 32'(occ));
      chk("valid", 32'(out_valid), 32'(occ != 0));
      chk("bx_cnt", 32'(bx_cnt), 32'(bx_m));
      chk("drop_cnt", 32'(drop_cnt), 32'(drop_m));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        else begin
          last_exp = exp_q.pop_front();
          chk("word", 32'(out_data), 32'(last_exp));
        end
      end else if (!out_valid) chk("hold_data", 32'(out_data), 32'(last_exp));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 0; bx_strobe = 0; cyc(2); rst_n = 1; cyc(1);
  endtask

  task automatic strobe(input logic [2:0] dv, input logic [12:0] d1, d2, d3);
    bx_strobe = 1; {hit3_dv, hit2_dv, hit1_dv} = dv;
    hit1_data = d1; hit2_data = d2; hit3_data = d3;
    cyc(1);
    bx_strobe = 0; {hit3_dv, hit2_dv, hit1_dv} = 3'b000;
  endtask

  task automatic rnd_strobe(input logic [2:0] dv);
    strobe(dv, 13'($urandom), 13'($urandom), 13'($urandom));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin cyc(1); n++; end
    chk("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  initial begin
    fe_id = 4'd3;
    do_reset();

    // Single hit on slot 2: word appears two cycles after the strobe.
    out_ready = 1;
    strobe(3'b010, 13'h0, 13'h0A5B, 13'h0);
    cyc(1);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_word", 32'(out_data), 32'({8'h00, 4'h3, 2'd2, 8'h52, 5'h1B}));
    chk("single_bx", 32'(bx_cnt), 1);
    wait_empty();

    // Ten full BX every 4 cycles, free-running consumer.
    for (int i = 0; i < 10; i++) begin rnd_strobe(3'b111); cyc(3); end
    wait_empty();
    chk("steady_drop", 32'(drop_cnt), 0);

    // Backpressure: fill the FIFO, then overrun a stalled bank.
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin rnd_strobe(3'b111); cyc(3); end
    chk("bp_full", 32'(fifo_level), DEPTH);
    rnd_strobe(3'b111);
    cyc(1);
    chk("bp_drop", 32'(drop_cnt), 2);
    out_ready = 1;
    wait_empty();

    // Back-to-back strobes: first BX keeps slot 1 only.
    do_reset();
    rnd_strobe(3'b111);
    rnd_strobe(3'b111);
    chk("overrun_drop", 32'(drop_cnt), 2);
    wait_empty();

    // Randomized traffic with random backpressure.
    fe_id = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) rnd_strobe(3'($urandom));
      else cyc(1);
    end
    out_ready = 1;
    wait_empty();

    // BX counter wrap: 257 strobes from reset.
    do_reset();
    for (int i = 0; i < 257; i++) begin rnd_strobe(3'b001); cyc(1); end
    chk("wrap_bx", 32'(bx_cnt), 1);
    wait_empty();

    // Reset while the FIFO holds five words.
    do_reset();
    out_ready = 0;
    rnd_strobe(3'b111); cyc(3);
    rnd_strobe(3'b011); cyc(3);
    chk("pre_rst_level", 32'(fifo_level), 5);
    rst_n = 0;
    #2;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_level", 32'(fifo_level), 0);
    cyc(2);
    rst_n = 1;
    cyc(2);
    chk("post_rst_level", 32'(fifo_level), 0);
    chk("post_rst_bx", 32'(bx_cnt), 0);
    out_ready = 1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
